// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and encodes alu_op for the ALU control decoder. Optional JUMP state under JUMP_EN.
module multicycle_main_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       ext_zero,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
`ifdef JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_XORIEX = 4'd9;
    localparam logic [3:0] S_XORIWB = 4'd10;
`ifdef JUMP_EN
    localparam logic [3:0] S_JUMP   = 4'd11;
`endif

    logic [3:0] state_r;
    logic [3:0] next_state_s;

    logic pc_write_s;
    logic pc_write_cond_s;
    logic mem_read_s;
    logic mem_write_s;
    logic ir_write_s;
    logic reg_write_s;
    logic illegal_op_s;

    // Opcodes this build knows how to sequence.
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_XORI: legal = 1'b1;
`ifdef JUMP_EN
            OP_J:                                    legal = 1'b1;
`endif
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; opcode is only consulted in DECODE and MEMADR.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXEC;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_XORI:      next_state_s = S_XORIEX;
`ifdef JUMP_EN
                    OP_J:         next_state_s = S_JUMP;
`endif
                    default:      next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    next_state_s = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    next_state_s = S_MEMWR;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_EXEC:   next_state_s = S_ALUWB;
            S_XORIEX: next_state_s = S_XORIWB;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // Moore output decode; FETCH strobes and DECODE illegal_op also see inputs.
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        reg_write_s     = 1'b0;
        illegal_op_s    = 1'b0;
        iord            = 1'b0;
        mem_to_reg      = 1'b0;
        reg_dst         = 1'b0;
        ext_zero        = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        pc_src          = 2'b00;
        case (state_r)
            S_FETCH: begin
                mem_read_s = 1'b1;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
            end
            S_DECODE: begin
                alu_src_b    = 2'b11;
                alu_op       = 2'b10;
                illegal_op_s = ~op_is_legal(opcode);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord       = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                iord        = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_src          = 2'b01;
            end
            S_XORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_zero  = 1'b1;
                alu_op    = 2'b11;
            end
            S_XORIWB: begin
                reg_write_s = 1'b1;
            end
`ifdef JUMP_EN
            S_JUMP: begin
                pc_write_s = 1'b1;
                pc_src     = 2'b10;
            end
`endif
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Strobes are forced low for as long as reset is held.
    assign pc_write      = pc_write_s      & rst_n;
    assign pc_write_cond = pc_write_cond_s & rst_n;
    assign mem_read      = mem_read_s      & rst_n;
    assign mem_write     = mem_write_s     & rst_n;
    assign ir_write      = ir_write_s      & rst_n;
    assign reg_write     = reg_write_s     & rst_n;
    assign illegal_op    = illegal_op_s    & rst_n;
    assign state         = state_r;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench: stimulus walks each instruction's phase list from an
// instruction-level model; a negedge monitor pops and compares every cycle.
module tb_multicycle_main_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, ext_zero, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, extz, asa;
        logic [1:0] asb, aop, psrc;
        logic       ill;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
        .ext_zero(ext_zero), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .state(state), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_legal(input logic [5:0] op);
        logic r;
        r = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b001110);
`ifdef JUMP_EN
        r = r || (op == 6'b000010);
`endif
        return r;
    endfunction

    // Expected control word for one cycle spent in phase ph.
    function automatic exp_t exp_for(input int ph, input logic mr, input logic ill);
        exp_t e;
        e = '0;
        e.st = 4'(ph);
        case (ph)
            0:  begin e.mrd = 1'b1; e.asb = 2'b01; e.aop = 2'b10; e.irw = mr; e.pcw = mr; end
            1:  begin e.asb = 2'b11; e.aop = 2'b10; e.ill = ill; end
            2:  begin e.asa = 1'b1; e.asb = 2'b10; e.aop = 2'b10; end
            3:  begin e.mrd = 1'b1; e.iord = 1'b1; end
            4:  begin e.rw = 1'b1; e.m2r = 1'b1; end
            5:  begin e.mwr = 1'b1; e.iord = 1'b1; end
            6:  begin e.asa = 1'b1; end
            7:  begin e.rw = 1'b1; e.rdst = 1'b1; end
            8:  begin e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1; e.psrc = 2'b01; end
            9:  begin e.asa = 1'b1; e.asb = 2'b10; e.extz = 1'b1; e.aop = 2'b11; end
            10: begin e.rw = 1'b1; end
            11: begin e.pcw = 1'b1; e.psrc = 2'b10; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    task automatic step(input int ph, input logic mr, input logic [5:0] op);
        mem_ready = mr;
        opcode    = op;
        expq.push_back(exp_for(ph, mr, (ph == 1) ? ~is_legal(op) : 1'b0));
        @(posedge clk);
        #1;
    endtask

    // A memory-handshake phase: n cycles with mem_ready low, then one high.
    task automatic wait_phase(input int ph, input int stalls, input logic [5:0] op);
        int n;
        n = (stalls < 0) ? int'($urandom_range(0, 2)) : stalls;
        for (int i = 0; i < n; i++) step(ph, 1'b0, op);
        step(ph, 1'b1, op);
    endtask

    task automatic run_instr(input logic [5:0] op, input int stalls);
        rst_n = 1'b1;
        wait_phase(0, stalls, rnd_op());
        step(1, 1'($urandom), op);
        if (is_legal(op)) begin
            case (op)
                6'b100011: begin
                    step(2, 1'($urandom), op);
                    wait_phase(3, stalls, rnd_op());
                    step(4, 1'($urandom), rnd_op());
                end
                6'b101011: begin
                    step(2, 1'($urandom), op);
                    wait_phase(5, stalls, rnd_op());
                end
                6'b000000: begin
                    step(6, 1'($urandom), rnd_op());
                    step(7, 1'($urandom), rnd_op());
                end
                6'b000100: step(8, 1'($urandom), rnd_op());
                6'b001110: begin
                    step(9, 1'($urandom), rnd_op());
                    step(10, 1'($urandom), rnd_op());
                end
                default:   step(11, 1'($urandom), rnd_op());
            endcase
        end
    endtask

    task automatic reset_cycle();
        exp_t e;
        rst_n = 1'b0;
        mem_ready = 1'($urandom);
        #1;
        e = exp_for(0, mem_ready, 1'b0);
        e.pcw = 1'b0; e.pcwc = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0;
        e.irw = 1'b0; e.rw = 1'b0; e.ill = 1'b0;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one scoreboard entry per cycle, sampled at the falling edge.
    always @(negedge clk) begin
        exp_t e, a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_write, reg_dst, ext_zero, alu_src_a,
                 alu_src_b, alu_op, pc_src, illegal_op};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL ctrl_word t=%0t actual=%h required=%h (state %0d vs %0d)",
                         $time, a, e, a.st, e.st);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] op;
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        reset_cycle();
        run_instr(6'b100011, 0);
        run_instr(6'b000000, 0);
        run_instr(6'b001110, 0);
        run_instr(6'b000100, 0);
        run_instr(6'b101011, 3);
        run_instr(6'b111111, 0);
        run_instr(6'b000010, 0);
        run_instr(6'b100011, 2);
        // Reset while a store is stalled in MEMWR.
        rst_n = 1'b1;
        step(0, 1'b1, rnd_op());
        step(1, 1'b0, 6'b101011);
        step(2, 1'b0, 6'b101011);
        step(5, 1'b0, rnd_op());
        reset_cycle();
        reset_cycle();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b001110;
                5: op = 6'b000010;
                default: op = rnd_op();
            endcase
            run_instr(op, -1);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d entries left required=0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle main control FSM; the encoding side of the ALUop interface consumed by the ALU control decoder.
- Decodes the 6-bit opcode of the instruction register and sequences fetch/decode/execute/memory/writeback.
- Each cycle it drives datapath strobes, mux selects and the 2-bit alu_op: 00 R-type (funct decode), 01 subtract (beq), 10 add (lw/sw/PC+4), 11 xor (xori).
- Sits between the instruction register and the datapath; stalls on a memory ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load word.
- OP_SW, 6'b101011, store word.
- OP_BEQ, 6'b000100, branch equal.
- OP_XORI, 6'b001110, xor immediate.
- OP_J, 6'b000010, jump (used only with JUMP_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26] from instruction register.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load instruction register.
- mem_to_reg  out  1  writeback data: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write.
- reg_dst  out  1  1 = rd, 0 = rt.
- ext_zero  out  1  1 = zero-extend immediate.
- alu_src_a  out  1  0 = PC, 1 = regA.
- alu_src_b  out  2  00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2.
- alu_op  out  2  to ALU control decoder.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  out  4  current state (debug).
- illegal_op  out  1  one-cycle pulse on an unrecognised opcode.

Behaviour:
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, XORIEX 9, XORIWB 10, JUMP 11. Codes 12–15 are unreachable and go to FETCH.
- Asynchronous reset: state = FETCH. While rst_n is low, all strobes are 0 (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) and illegal_op = 0. The first fetch request occurs in the cycle after rst_n deasserts. Reset mid-instruction abandons the instruction with no write.
- Outputs are decoded combinationally from state (Moore). Exceptions: FETCH ir_write and pc_write equal mem_ready; illegal_op is combinational in DECODE. Any signal not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=10, pc_src=00. Stay while !mem_ready; go to DECODE when mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=10 (branch target precompute). Next state by opcode:
  - LW/SW → MEMADR
  - RTYPE → EXEC
  - BEQ → BRANCH
  - XORI → XORIEX
  - other → FETCH with illegal_op=1
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=10. LW → MEMRD, SW → MEMWR.
- MEMRD: mem_read=1, iord=1. Wait for mem_ready, then → MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: mem_write=1, iord=1. Wait for mem_ready, then → FETCH. mem_write is held high throughout the wait.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=00 → ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01 → FETCH.
- XORIEX: alu_src_a=1, alu_src_b=10, ext_zero=1, alu_op=11 → XORIWB.
- XORIWB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- Cycle counts with mem_ready always 1: lw 5, sw 4, R-type 4, xori 4, beq 3, illegal 2. Each cycle mem_ready is low adds one cycle in FETCH, MEMRD or MEMWR.
- opcode is sampled only in DECODE and MEMADR; changes in other states are ignored.
- mem_read and mem_write are never both 1.

Optional Feature:
- Macro JUMP_EN.
- Defined: OP_J in DECODE → JUMP. JUMP drives pc_write=1, pc_src=10, then → FETCH (3 cycles total).
- Undefined: the JUMP state is not built; OP_J takes the illegal path (illegal_op pulse, → FETCH). pc_src never equals 10.

Test Plan:
- Reset with rst_n=0 mid-MEMWR → state=0 immediately, mem_write=0, all strobes 0; after release, mem_read=1 on the next cycle.
- lw (opcode 100011), mem_ready=1 → state sequence 0,1,2,3,4,0; alu_op 10 in MEMADR; reg_write=1 with mem_to_reg=1 only in MEMWB.
- R-type (000000) then xori (001110) → alu_op=00 in EXEC with reg_dst=1; alu_op=11 with ext_zero=1 in XORIEX; reg_dst=0 in XORIWB.
- beq (000100) → BRANCH shows alu_op=01, pc_write_cond=1, pc_src=01; back to FETCH after 3 cycles.
- sw with mem_ready low for 3 cycles in MEMWR → mem_write held 3+1 cycles; no reg_write; returns to FETCH.
- Opcode 111111 (and 000010 without JUMP_EN) → illegal_op=1 for exactly one cycle in DECODE, then FETCH. With JUMP_EN, 000010 → JUMP with pc_write=1, pc_src=10.
